// File: rtl/prm_edge_scan_sched.sv
// rtl/prm_edge_scan_sched.sv - obstacle-code sequencer and blocked-edge accumulator for the PRM checker array
module prm_edge_scan_sched #(
    parameter int NUM_EDGES = 1024,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 obs_valid,
    output logic                 obs_ready,
    input  logic [14:0]          obs_code,
    input  logic                 obs_last,
    output logic [14:0]          chk_code,
    input  logic [NUM_EDGES-1:0] chk_mask,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WORD_W-1:0]    res_data,
    output logic                 res_last,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     obs_count
);

    localparam int NW     = (NUM_EDGES + WORD_W - 1) / WORD_W;
    localparam int WIDX_W = $clog2(NW) + 1;
    localparam int PAD_W  = NW * WORD_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [14:0]            r_chk_code;
    logic                   r_chk_vld;
    logic [NUM_EDGES-1:0]   r_acc;
    logic [CNT_W-1:0]       r_obs_count;
    logic [WIDX_W-1:0]      r_widx;
    logic                   r_done;

    logic                   w_obs_hs;
    logic                   w_res_hs;
    logic                   w_res_last;
    logic                   w_start_ok;
    logic [PAD_W-1:0]       w_acc_pad;
    logic [WORD_W-1:0]      w_word;
    int                     w_base;

    assign w_obs_hs   = obs_valid && (r_state == S_SCAN);
    assign w_res_hs   = res_ready && (r_state == S_OUT);
    assign w_res_last = (r_widx == WIDX_W'(NW - 1));
    // The done cycle is still the tail of the previous scan, so start is masked there.
    assign w_start_ok = start && !r_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_SCAN;
            S_SCAN:  if (w_obs_hs && obs_last) w_next = S_FLUSH;
            S_FLUSH: w_next = S_OUT;
            S_OUT:   if (w_res_hs && w_res_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_chk_code  <= '0;
            r_chk_vld   <= 1'b0;
            r_acc       <= '0;
            r_obs_count <= '0;
            r_widx      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_acc       <= '0;
                        r_obs_count <= '0;
                        r_chk_vld   <= 1'b0;
                    end
                end
                S_SCAN: begin
                    // chk_mask reflects the code registered on the previous handshake.
                    if (r_chk_vld) begin
                        r_acc <= r_acc | chk_mask;
                    end
                    if (w_obs_hs) begin
                        r_chk_code <= obs_code;
                        r_chk_vld  <= 1'b1;
                        if (!(&r_obs_count)) begin
                            r_obs_count <= r_obs_count + 1'b1;
                        end
                    end else begin
                        r_chk_vld <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (r_chk_vld) begin
                        r_acc <= r_acc | chk_mask;
                    end
                    r_chk_vld <= 1'b0;
                    r_widx    <= '0;
                end
                S_OUT: begin
                    if (w_res_hs) begin
                        if (w_res_last) begin
                            r_done <= 1'b1;
                        end else begin
                            r_widx <= r_widx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Zero-pad the accumulator so the top word reads 0 above NUM_EDGES.
    always_comb begin
        w_acc_pad                  = '0;
        w_acc_pad[NUM_EDGES-1:0]   = r_acc;
        w_base                     = int'(r_widx) * WORD_W;
        w_word                     = w_acc_pad[w_base +: WORD_W];
    end

    assign obs_ready = (r_state == S_SCAN);
    assign res_valid = (r_state == S_OUT);
    assign res_data  = (r_state == S_OUT) ? w_word : '0;
    assign res_last  = (r_state == S_OUT) && w_res_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign chk_code  = r_chk_code;
    assign obs_count = r_obs_count;

endmodule

// File: tb/tb_prm_edge_scan_sched.sv
// tb/tb_prm_edge_scan_sched.sv - directed scoreboard bench for prm_edge_scan_sched
module tb_prm_edge_scan_sched;

    localparam int NE = 40;
    localparam int WW = 32;
    localparam int CW = 16;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          obs_valid = 1'b0;
    logic          obs_ready;
    logic [14:0]   obs_code = '0;
    logic          obs_last = 1'b0;
    logic [14:0]   chk_code;
    logic [NE-1:0] chk_mask;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [WW-1:0] res_data;
    logic          res_last;
    logic          busy;
    logic          done;
    logic [CW-1:0] obs_count;

    typedef struct {
        logic [WW-1:0] d;
        logic          l;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] model_acc;
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          hs_cnt = 0;

    prm_edge_scan_sched #(.NUM_EDGES(NE), .WORD_W(WW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .obs_valid(obs_valid), .obs_ready(obs_ready), .obs_code(obs_code), .obs_last(obs_last),
        .chk_code(chk_code), .chk_mask(chk_mask),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .busy(busy), .done(done), .obs_count(obs_count)
    );

    // Checker array model: instance k flags the edge iff the code equals k.
    always_comb begin
        chk_mask = '0;
        if (chk_code < 15'(NE)) chk_mask[chk_code[5:0]] = 1'b1;
    end

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (res_valid === 1'b1 && res_ready === 1'b1) hs_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        model_acc = '0;
        done_cnt = 0;
    endtask

    task automatic send(input int code, input bit last, input int gap);
        obs_valid = 1'b1;
        obs_code  = 15'(code);
        obs_last  = last;
        chk("obs_ready", obs_ready, 1);
        tick();
        obs_valid = 1'b0;
        obs_last  = 1'b0;
        if (code < NE) model_acc[code] = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic push_words;
        exp_t e;
        for (int w = 0; w < NW; w++) begin
            e.d = model_acc[w*WW +: WW];
            e.l = (w == NW - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic read_out(input int stall, input bit start_in_out);
        int          guard;
        exp_t        e;
        logic [WW-1:0] held;
        guard = 0;
        hs_cnt = 0;
        while (res_valid !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk("res_valid_wait", res_valid, 1);
        for (int w = 0; w < NW; w++) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 0, 1);
                return;
            end
            e = sbq.pop_front();
            if (w == 0 && stall > 0) begin
                res_ready = 1'b0;
                held = res_data;
                if (start_in_out) start = 1'b1;
                repeat (stall) begin
                    tick();
                    chk("stall_data", res_data, held);
                    chk("stall_valid", res_valid, 1);
                end
                start = 1'b0;
            end
            res_ready = 1'b1;
            chk($sformatf("word%0d_data", w), res_data, e.d);
            chk($sformatf("word%0d_last", w), res_last, e.l);
            tick();
            res_ready = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("hs_per_word", hs_cnt, NW);
    endtask

    initial begin
        model_acc = '0;
        // Reset
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_obs_ready", obs_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_done", done, 0);
        chk("rst_chk_code", chk_code, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_obs_count", obs_count, 0);
        tick();

        // Single code with latency check
        do_start();
        chk("a_busy", busy, 1);
        send(5, 1, 0);
        chk("a_flush_valid", res_valid, 0);
        push_words();
        tick();
        chk("a_latency_valid", res_valid, 1);
        read_out(0, 0);
        chk("a_obs_count", obs_count, 1);
        tick();
        chk("a_done_low", done, 0);
        chk("a_done_cnt", done_cnt, 1);

        // OR accumulation with gaps, start during SCAN and OUT, backpressure
        do_start();
        send(0, 0, 1);
        start = 1'b1;
        send(31, 0, 2);
        start = 1'b0;
        send(33, 0, 1);
        send(39, 1, 0);
        push_words();
        chk("b_model_w0", model_acc[31:0], 64'h8000_0001);
        read_out(3, 1);
        chk("b_obs_count", obs_count, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b_start_at_done_ignored", busy, 0);
        chk("b_done_cnt", done_cnt, 1);

        // Start one cycle after done, then reset mid-scan
        do_start();
        chk("c_busy", busy, 1);
        chk("c_count_cleared", obs_count, 0);
        send(3, 0, 0);
        send(7, 0, 0);
        chk("c_count2", obs_count, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("c_rst_busy", busy, 0);
        chk("c_rst_obs_ready", obs_ready, 0);
        chk("c_rst_count", obs_count, 0);
        repeat (3) tick();
        chk("c_stays_idle", busy, 0);
        chk("c_no_done", done_cnt, 0);

        // Fresh scan after reset
        do_start();
        send(10, 1, 0);
        push_words();
        read_out(0, 0);
        chk("d_obs_count", obs_count, 1);
        tick();
        chk("d_done_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
